// File: rtl/mult2x3_accumulator_pkg.sv
// mult2x3_accumulator_pkg
// Shared definitions for the multiply-accumulate consumer block:
//   - PRODUCT_WIDTH : width of the product from the 2x3 array multiplier
//   - state_t       : controller states (ACCUM collects products, DONE presents the sum)
//   - cntWidth()    : width of the product counter for a given COUNT (never below 1 bit)
package mult2x3_accumulator_pkg;

    localparam int PRODUCT_WIDTH = 5;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_t;

    // $clog2(1) is 0, which would give a zero-width counter, so clamp to 1 bit.
    function automatic int cntWidth(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

endpackage

// File: rtl/mult2x3_accumulator_if.sv
// mult2x3_accumulator_if
// Bundles the product input handshake, the synchronous clear, and the result
// output handshake of the accumulator.
//   product/pValid/pReady : product stream from the array multiplier
//   clear                 : abort the accumulation in progress
//   accSum/accValid/accReady/overflow : finished result stream
// Modports: master = environment driving products and consuming results,
//           slave  = the accumulator itself.
interface mult2x3_accumulator_if #(
    parameter int ACC_WIDTH = 12
);
    import mult2x3_accumulator_pkg::*;

    logic [PRODUCT_WIDTH-1:0] product;
    logic                     pValid;
    logic                     pReady;
    logic                     clear;
    logic [ACC_WIDTH-1:0]     accSum;
    logic                     accValid;
    logic                     accReady;
    logic                     overflow;

    modport master (
        output product, pValid, clear, accReady,
        input  pReady, accSum, accValid, overflow
    );

    modport slave (
        input  product, pValid, clear, accReady,
        output pReady, accSum, accValid, overflow
    );

endinterface

// File: rtl/Adder1Bit.sv
// Adder1Bit
// Single-bit full adder, the building block of the accumulator's ripple adder.
//   a, b, cin : addend bits and carry in
//   sum, cout : sum bit and carry out
module Adder1Bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/acc_adder.sv
// acc_adder
// WIDTH-bit ripple-carry adder made of a chain of Adder1Bit cells.
//   a, b : operands
//   sum  : a + b modulo 2^WIDTH
//   cout : carry out of the top bit (the accumulator uses it as its overflow source)
module acc_adder #(
    parameter int WIDTH = 12
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // Each stage owns its carry signals so the chain is a set of distinct nets
    // rather than one vector feeding back into itself.
    for (genvar i = 0; i < WIDTH; i++) begin : stage
        logic carry_in;
        logic carry_out;

        if (i == 0) begin : g_first
            assign carry_in = 1'b0;
        end else begin : g_rest
            assign carry_in = stage[i-1].carry_out;
        end

        Adder1Bit u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (carry_in),
            .sum  (sum[i]),
            .cout (carry_out)
        );
    end

    assign cout = stage[WIDTH-1].carry_out;

endmodule

// File: rtl/mult2x3_accumulator.sv
// mult2x3_accumulator
// Sums COUNT unsigned 5-bit products into an ACC_WIDTH-bit accumulator and
// presents the result with a sticky overflow flag.
//   clock : system clock, rising edge
//   reset : asynchronous active-high reset
//   bus   : slave side of mult2x3_accumulator_if (product in, result out)
module mult2x3_accumulator
    import mult2x3_accumulator_pkg::*;
#(
    parameter int ACC_WIDTH = 12,
    parameter int COUNT     = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    mult2x3_accumulator_if.slave   bus
);

    localparam int                  CNT_WIDTH = cntWidth(COUNT);
    localparam logic [CNT_WIDTH-1:0] LAST     = CNT_WIDTH'(COUNT - 1);

    state_t                state;
    state_t                next_state;
    logic [ACC_WIDTH-1:0]  acc;
    logic [ACC_WIDTH-1:0]  add_sum;
    logic [ACC_WIDTH-1:0]  product_ext;
    logic                  add_carry;
    logic [CNT_WIDTH-1:0]  cnt;
    logic                  ovf;
    logic                  accept;
    logic                  handshake;

    assign product_ext = ACC_WIDTH'(bus.product);
    assign accept      = bus.pValid && bus.pReady;
    assign handshake   = bus.accValid && bus.accReady;

    acc_adder #(
        .WIDTH (ACC_WIDTH)
    ) u_adder (
        .a    (acc),
        .b    (product_ext),
        .sum  (add_sum),
        .cout (add_carry)
    );

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ACCUM;
        end else begin
            state <= next_state;
        end
    end

    // The last accept of a batch ends collection; only the output handshake
    // leaves DONE, so clear can never throw away a finished result.
    always_comb begin
        next_state = state;
        case (state)
            ACCUM:   if (accept && (cnt == LAST)) next_state = DONE;
            DONE:    if (handshake) next_state = ACCUM;
            default: next_state = ACCUM;
        endcase
    end

    // pReady depends only on state and clear, never on pValid, so clear
    // beats a simultaneous product.
    always_comb begin
        bus.pReady   = (state == ACCUM) && !bus.clear;
        bus.accValid = (state == DONE);
        bus.accSum   = acc;
        bus.overflow = ovf;
    end

    // Datapath: accumulator, sticky carry flag and product counter.
    // The counter wraps to 0 on the last accept so it is ready for the next batch.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
        end else if (state == ACCUM) begin
            if (bus.clear) begin
                acc <= '0;
                cnt <= '0;
                ovf <= 1'b0;
            end else if (accept) begin
                acc <= add_sum;
                if (add_carry) ovf <= 1'b1;
                cnt <= (cnt == LAST) ? '0 : cnt + CNT_WIDTH'(1);
            end
        end else if (handshake) begin
            acc <= '0;
            ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mult2x3_accumulator.sv
// tb_mult2x3_accumulator
// Three accumulators with different parameters share one input stream:
//   dut0: ACC_WIDTH 12, COUNT 8   dut1: ACC_WIDTH 8, COUNT 16   dut2: ACC_WIDTH 12, COUNT 1
// A plain arithmetic model tracks each one's running total and product count.
module tb_mult2x3_accumulator;

    logic       clock    = 1'b0;
    logic       reset    = 1'b1;
    logic [4:0] product  = '0;
    logic       pValid   = 1'b0;
    logic       clear    = 1'b0;
    logic       accReady = 1'b0;

    int checks = 0;
    int errors = 0;

    localparam int W [3] = '{12, 8, 12};
    localparam int C [3] = '{8, 16, 1};

    always #5 clock = ~clock;

    mult2x3_accumulator_if #(.ACC_WIDTH(12)) bus0 ();
    mult2x3_accumulator_if #(.ACC_WIDTH(8))  bus1 ();
    mult2x3_accumulator_if #(.ACC_WIDTH(12)) bus2 ();

    assign bus0.product = product;  assign bus0.pValid = pValid;
    assign bus0.clear   = clear;    assign bus0.accReady = accReady;
    assign bus1.product = product;  assign bus1.pValid = pValid;
    assign bus1.clear   = clear;    assign bus1.accReady = accReady;
    assign bus2.product = product;  assign bus2.pValid = pValid;
    assign bus2.clear   = clear;    assign bus2.accReady = accReady;

    mult2x3_accumulator #(.ACC_WIDTH(12), .COUNT(8))  dut0 (.clock(clock), .reset(reset), .bus(bus0));
    mult2x3_accumulator #(.ACC_WIDTH(8),  .COUNT(16)) dut1 (.clock(clock), .reset(reset), .bus(bus1));
    mult2x3_accumulator #(.ACC_WIDTH(12), .COUNT(1))  dut2 (.clock(clock), .reset(reset), .bus(bus2));

    logic [11:0] dutSum   [3];
    logic        dutValid [3];
    logic        dutReady [3];
    logic        dutOvf   [3];

    assign dutSum[0] = bus0.accSum;          assign dutSum[1] = {4'b0, bus1.accSum};
    assign dutSum[2] = bus2.accSum;
    assign dutValid[0] = bus0.accValid;      assign dutValid[1] = bus1.accValid;
    assign dutValid[2] = bus2.accValid;
    assign dutReady[0] = bus0.pReady;        assign dutReady[1] = bus1.pReady;
    assign dutReady[2] = bus2.pReady;
    assign dutOvf[0] = bus0.overflow;        assign dutOvf[1] = bus1.overflow;
    assign dutOvf[2] = bus2.overflow;

    // Model: the true (unbounded) total of products in the current result,
    // how many have been taken, and whether the result is waiting downstream.
    longint mAcc  [3];
    int     mCnt  [3];
    bit     mDone [3];

    always @(posedge clock or posedge reset) begin
        for (int i = 0; i < 3; i++) begin
            if (reset) begin
                mAcc[i] <= 0; mCnt[i] <= 0; mDone[i] <= 1'b0;
            end else if (!mDone[i]) begin
                if (clear) begin
                    mAcc[i] <= 0; mCnt[i] <= 0;
                end else if (pValid) begin
                    mAcc[i] <= mAcc[i] + longint'(product);
                    if (mCnt[i] + 1 == C[i]) begin
                        mDone[i] <= 1'b1; mCnt[i] <= 0;
                    end else begin
                        mCnt[i] <= mCnt[i] + 1;
                    end
                end
            end else if (accReady) begin
                mDone[i] <= 1'b0; mAcc[i] <= 0;
            end
        end
    end

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d required=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clock) begin
        if (!reset) begin
            for (int i = 0; i < 3; i++) begin
                longint modv;
                modv = longint'(1) << W[i];
                checkOutput($sformatf("dut%0d.accValid", i), longint'(dutValid[i]), longint'(mDone[i]));
                checkOutput($sformatf("dut%0d.pReady", i), longint'(dutReady[i]),
                            longint'(!mDone[i] && !clear));
                checkOutput($sformatf("dut%0d.accSum", i), longint'(dutSum[i]), mAcc[i] % modv);
                checkOutput($sformatf("dut%0d.overflow", i), longint'(dutOvf[i]),
                            longint'(mAcc[i] >= modv));
            end
        end
    end

    // Drive one cycle of inputs and return just after the capturing edge.
    task automatic applyStimulus(input logic [4:0] p, input logic v, input logic c, input logic r);
        product  = p;
        pValid   = v;
        clear    = c;
        accReady = r;
        @(posedge clock);
        #1;
    endtask

    task automatic doReset();
        reset = 1'b1;
        applyStimulus(5'd0, 1'b0, 1'b0, 1'b0);
        applyStimulus(5'd0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
    endtask

    initial begin
        doReset();
        checkOutput("reset.pReady", longint'(dutReady[0]), 1);
        checkOutput("reset.accSum", longint'(dutSum[0]), 0);

        // Basic sum: 8 x 21 = 168 on dut0.
        for (int k = 0; k < 8; k++) applyStimulus(5'd21, 1'b1, 1'b0, 1'b0);
        checkOutput("basic.accValid", longint'(dutValid[0]), 1);
        checkOutput("basic.accSum", longint'(dutSum[0]), 168);
        checkOutput("basic.overflow", longint'(dutOvf[0]), 0);

        // Backpressure: hold the result for 5 cycles with a product pending.
        for (int k = 0; k < 5; k++) begin
            applyStimulus(5'd3, 1'b1, 1'b0, 1'b0);
            checkOutput("stall.accSum", longint'(dutSum[0]), 168);
            checkOutput("stall.pReady", longint'(dutReady[0]), 0);
        end
        applyStimulus(5'd3, 1'b1, 1'b0, 1'b1);
        checkOutput("release.pReady", longint'(dutReady[0]), 1);
        checkOutput("release.accSum", longint'(dutSum[0]), 0);
        applyStimulus(5'd3, 1'b1, 1'b0, 1'b0);
        checkOutput("restart.accSum", longint'(dutSum[0]), 3);

        // Overflow on dut1: 16 x 21 = 336, 336 mod 256 = 80.
        doReset();
        for (int k = 0; k < 16; k++) applyStimulus(5'd21, 1'b1, 1'b0, 1'b0);
        checkOutput("ovf.accValid", longint'(dutValid[1]), 1);
        checkOutput("ovf.accSum", longint'(dutSum[1]), 80);
        checkOutput("ovf.overflow", longint'(dutOvf[1]), 1);
        applyStimulus(5'd0, 1'b0, 1'b0, 1'b1);
        checkOutput("ovf.cleared", longint'(dutOvf[1]), 0);

        // Clear: 3 x 5, then clear with a colliding 7, then 8 x 1 = 8.
        doReset();
        for (int k = 0; k < 3; k++) applyStimulus(5'd5, 1'b1, 1'b0, 1'b0);
        applyStimulus(5'd7, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 8; k++) applyStimulus(5'd1, 1'b1, 1'b0, 1'b0);
        checkOutput("clear.accValid", longint'(dutValid[0]), 1);
        checkOutput("clear.accSum", longint'(dutSum[0]), 8);

        // Asynchronous reset while a result is pending.
        #2 reset = 1'b1;
        #1;
        checkOutput("areset.accValid", longint'(dutValid[0]), 0);
        checkOutput("areset.accSum", longint'(dutSum[0]), 0);
        checkOutput("areset.overflow", longint'(dutOvf[0]), 0);
        @(posedge clock);
        #1 reset = 1'b0;
        checkOutput("areset.pReady", longint'(dutReady[0]), 1);

        // Gaps: products 1..8 each followed by an idle cycle, total 36.
        doReset();
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(5'(k), 1'b1, 1'b0, 1'b0);
            applyStimulus(5'd0, 1'b0, 1'b0, 1'b0);
        end
        checkOutput("gaps.accValid", longint'(dutValid[0]), 1);
        checkOutput("gaps.accSum", longint'(dutSum[0]), 36);

        // COUNT = 1: each accepted product is a result on its own.
        doReset();
        applyStimulus(5'd9, 1'b1, 1'b0, 1'b0);
        checkOutput("single.accValid", longint'(dutValid[2]), 1);
        checkOutput("single.accSum", longint'(dutSum[2]), 9);
        applyStimulus(5'd4, 1'b1, 1'b0, 1'b1);
        applyStimulus(5'd4, 1'b1, 1'b0, 1'b1);
        checkOutput("single2.accSum", longint'(dutSum[2]), 4);

        // Random gaps, backpressure and occasional clears, checked by the model.
        for (int k = 0; k < 200; k++) begin
            applyStimulus(5'($urandom_range(0, 21)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
